// File: rtl/alu_multiciclo_if.sv
// Handshake and operand/result bundle between EX-stage control and the multi-cycle ALU.
// The master side issues Start with operands; the slave side returns Busy/Done and the results.
interface alu_multiciclo_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [WIDTH-1:0] Op_1;
   logic [WIDTH-1:0] Op_2;
   logic [3:0]       Op_Alu;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Res;
   logic             ZF;
   logic             DZ;

   modport master (
      output Start, Op_1, Op_2, Op_Alu,
      input  Busy, Done, Res, ZF, DZ
   );

   modport slave (
      input  Start, Op_1, Op_2, Op_Alu,
      output Busy, Done, Res, ZF, DZ
   );
endinterface

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus iterative unsigned
// divide/remainder (one quotient bit per clock) and integer square root (two radicand bits per clock).
module alu_multiciclo #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             rst,
   alu_multiciclo_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int HW  = WIDTH / 2;
   localparam int SW  = HW + 3;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_MUL   = 4'b0011;
   localparam logic [3:0] OP_REMU  = 4'b0100;
   localparam logic [3:0] OP_ISQRT = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_DIVU  = 4'b1000;
   localparam logic [3:0] OP_SLL   = 4'b1111;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_SQRT, S_FIN} state_t;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] dsr_q, quo_q, rem_q, rad_q;
   logic [HW:0]      srem_q;
   logic [HW-1:0]    root_q;
   logic [WIDTH-1:0] res_q;
   logic             zf_q, dz_q;

   logic             accept, div_last, sq_last, div_ge, sq_ge;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] quo_d, rem_d, single_res, div_res, sq_res;
   logic [SW-1:0]    sq_rt, sq_trial;
   logic [HW:0]      srem_d;
   logic [HW-1:0]    root_d;

   function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_SLT:  return (a < b) ? WIDTH'(1) : '0;
         OP_SLL:  return b << a[SHW-1:0];
         OP_MUL:  return a * b;
         default: return '0;
      endcase
   endfunction

   assign accept     = bus.Start && (state_q == S_IDLE || state_q == S_FIN);
   assign div_last   = (cnt_q == SHW'(WIDTH - 1));
   assign sq_last    = (cnt_q == SHW'(HW - 1));
   assign single_res = alu_single(bus.Op_Alu, bus.Op_1, bus.Op_2);

   // Restoring divide step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
   always_comb begin
      div_trial = {rem_q, quo_q[WIDTH-1]};
      div_ge    = (div_trial >= {1'b0, dsr_q});
      rem_d     = div_ge ? (div_trial[WIDTH-1:0] - dsr_q) : div_trial[WIDTH-1:0];
      quo_d     = {quo_q[WIDTH-2:0], div_ge};
      div_res   = (op_q == OP_REMU) ? rem_d : quo_d;
   end

   // Digit-by-digit root step: compare {rem, next two bits} against {root, 01}.
   always_comb begin
      sq_rt    = {srem_q, rad_q[WIDTH-1 -: 2]};
      sq_trial = {1'b0, root_q, 2'b01};
      sq_ge    = (sq_rt >= sq_trial);
      srem_d   = sq_ge ? (sq_rt[HW:0] - sq_trial[HW:0]) : sq_rt[HW:0];
      root_d   = {root_q[HW-2:0], sq_ge};
      sq_res   = {{(WIDTH - HW){1'b0}}, root_d};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_FIN: begin
            if (bus.Start) begin
               case (bus.Op_Alu)
                  OP_DIVU, OP_REMU: state_d = S_DIV;
                  OP_ISQRT:         state_d = S_SQRT;
                  default:          state_d = S_FIN;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DIV:   if (div_last) state_d = S_FIN;
         S_SQRT:  if (sq_last)  state_d = S_FIN;
         default: state_d = S_IDLE;
      endcase
   end

   // Control and visible results: reset aborts any in-flight op.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         zf_q    <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q <= '0;
            if (state_d == S_FIN) begin
               res_q <= single_res;
               zf_q  <= (single_res == '0);
               dz_q  <= 1'b0;
            end
         end else if (state_q == S_DIV) begin
            cnt_q <= cnt_q + SHW'(1);
            if (div_last) begin
               res_q <= div_res;
               zf_q  <= (div_res == '0);
               dz_q  <= (dsr_q == '0);
            end
         end else if (state_q == S_SQRT) begin
            cnt_q <= cnt_q + SHW'(1);
            if (sq_last) begin
               res_q <= sq_res;
               zf_q  <= (sq_res == '0);
               dz_q  <= 1'b0;
            end
         end
      end
   end

   // Iteration datapath: only meaningful after an accepted Start, so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= bus.Op_Alu;
         dsr_q  <= bus.Op_2;
         quo_q  <= bus.Op_1;
         rem_q  <= '0;
         rad_q  <= bus.Op_1;
         srem_q <= '0;
         root_q <= '0;
      end else if (state_q == S_DIV) begin
         quo_q <= quo_d;
         rem_q <= rem_d;
      end else if (state_q == S_SQRT) begin
         rad_q  <= {rad_q[WIDTH-3:0], 2'b00};
         srem_q <= srem_d;
         root_q <= root_d;
      end
   end

   assign bus.Busy = (state_q == S_DIV) || (state_q == S_SQRT);
   assign bus.Done = (state_q == S_FIN);
   assign bus.Res  = res_q;
   assign bus.ZF   = zf_q;
   assign bus.DZ   = dz_q;
endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo: table of single/iterative ops on a 32-bit instance,
// plus handshake, reset-abort and 8-bit square-root sequences.
module tb_alu_multiciclo;
   localparam logic [3:0] AND_  = 4'b0000;
   localparam logic [3:0] OR_   = 4'b0001;
   localparam logic [3:0] ADD   = 4'b0010;
   localparam logic [3:0] MUL   = 4'b0011;
   localparam logic [3:0] REMU  = 4'b0100;
   localparam logic [3:0] ISQRT = 4'b0101;
   localparam logic [3:0] SUB   = 4'b0110;
   localparam logic [3:0] SLT   = 4'b0111;
   localparam logic [3:0] DIVU  = 4'b1000;
   localparam logic [3:0] SLL   = 4'b1111;
   localparam logic [3:0] BAD   = 4'b1001;
   localparam int NV = 24;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_multiciclo_if #(.WIDTH(32)) bus32 ();
   alu_multiciclo_if #(.WIDTH(8))  bus8 ();

   alu_multiciclo #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
   alu_multiciclo #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zf;
      logic        dz;
   } vec_t;

   vec_t vecs [NV];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic int lat32(input logic [3:0] op);
      if (op == DIVU || op == REMU) return 33;
      if (op == ISQRT) return 17;
      return 1;
   endfunction

   // Called at a negedge: that cycle is cycle 0, Start is sampled at the next rising edge.
   task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zf, input logic exp_dz, input int exp_lat);
      logic [31:0] prev_res;
      int done_cyc, pat_err, hold_err;
      prev_res = bus32.Res;
      done_cyc = -1;
      pat_err  = 0;
      hold_err = 0;
      bus32.Start  = 1'b1;
      bus32.Op_Alu = op;
      bus32.Op_1   = a;
      bus32.Op_2   = b;
      for (int c = 1; c <= exp_lat + 4 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) bus32.Start = 1'b0;
         if (bus32.Done) done_cyc = c;
         if (bus32.Busy !== (c < exp_lat)) pat_err++;
         if (!bus32.Done && bus32.Res !== prev_res) hold_err++;
      end
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_lat));
      check({tag, " busy_pattern_errs"}, 32'(pat_err), 32'd0);
      check({tag, " res_hold_errs"}, 32'(hold_err), 32'd0);
      check({tag, " res"}, bus32.Res, exp_res);
      check({tag, " zf"}, 32'(bus32.ZF), 32'(exp_zf));
      check({tag, " dz"}, 32'(bus32.DZ), 32'(exp_dz));
   endtask

   task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_res, input int exp_lat);
      int done_cyc;
      done_cyc = -1;
      bus8.Start  = 1'b1;
      bus8.Op_Alu = op;
      bus8.Op_1   = a;
      bus8.Op_2   = b;
      for (int c = 1; c <= exp_lat + 4 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1) bus8.Start = 1'b0;
         if (bus8.Done) done_cyc = c;
      end
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_lat));
      check({tag, " res"}, {24'd0, bus8.Res}, {24'd0, exp_res});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cyc, late_done;

      vecs[0]  = '{ADD,   32'd7,          32'd5,          32'd12,         1'b0, 1'b0};
      vecs[1]  = '{SUB,   32'd5,          32'd5,          32'd0,          1'b1, 1'b0};
      vecs[2]  = '{SLT,   32'd3,          32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0};
      vecs[3]  = '{SLT,   32'd5,          32'd3,          32'd0,          1'b1, 1'b0};
      vecs[4]  = '{SLL,   32'd4,          32'd3,          32'd48,         1'b0, 1'b0};
      vecs[5]  = '{AND_,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0};
      vecs[6]  = '{OR_,   32'h0000_00F0,  32'h0000_0F00,  32'h0000_0FF0,  1'b0, 1'b0};
      vecs[7]  = '{MUL,   32'd12345,      32'd1000,       32'd12345000,   1'b0, 1'b0};
      vecs[8]  = '{MUL,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b0, 1'b0};
      vecs[9]  = '{BAD,   32'd7,          32'd5,          32'd0,          1'b1, 1'b0};
      vecs[10] = '{DIVU,  32'd100,        32'd7,          32'd14,         1'b0, 1'b0};
      vecs[11] = '{REMU,  32'd100,        32'd7,          32'd2,          1'b0, 1'b0};
      vecs[12] = '{DIVU,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
      vecs[13] = '{DIVU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0};
      vecs[14] = '{REMU,  32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  1'b0, 1'b0};
      vecs[15] = '{DIVU,  32'd9,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b1};
      vecs[16] = '{REMU,  32'd9,          32'd0,          32'd9,          1'b0, 1'b1};
      vecs[17] = '{ADD,   32'd1,          32'd1,          32'd2,          1'b0, 1'b0};
      vecs[18] = '{ISQRT, 32'd99,         32'd0,          32'd9,          1'b0, 1'b0};
      vecs[19] = '{ISQRT, 32'd100,        32'd0,          32'd10,         1'b0, 1'b0};
      vecs[20] = '{ISQRT, 32'd0,          32'd0,          32'd0,          1'b1, 1'b0};
      vecs[21] = '{ISQRT, 32'hFFFF_FFFF,  32'd0,          32'd65535,      1'b0, 1'b0};
      vecs[22] = '{ISQRT, 32'd1000,       32'd0,          32'd31,         1'b0, 1'b0};
      vecs[23] = '{REMU,  32'd0,          32'd5,          32'd0,          1'b1, 1'b0};

      rst = 1'b1;
      bus32.Start = 1'b0; bus32.Op_Alu = '0; bus32.Op_1 = '0; bus32.Op_2 = '0;
      bus8.Start  = 1'b0; bus8.Op_Alu  = '0; bus8.Op_1  = '0; bus8.Op_2  = '0;
      repeat (3) @(negedge clk);
      check("reset res",  bus32.Res, 32'd0);
      check("reset zf",   32'(bus32.ZF), 32'd0);
      check("reset dz",   32'(bus32.DZ), 32'd0);
      check("reset busy", 32'(bus32.Busy), 32'd0);
      check("reset done", 32'(bus32.Done), 32'd0);
      check("reset8 busy_done", {30'd0, bus8.Busy, bus8.Done}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++)
         run32($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].zf, vecs[i].dz, lat32(vecs[i].op));

      // Start and operand changes while busy must not disturb the divide.
      done_cyc = -1;
      bus32.Start = 1'b1; bus32.Op_Alu = DIVU; bus32.Op_1 = 32'd50; bus32.Op_2 = 32'd5;
      for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
         @(negedge clk);
         if (c == 1)  bus32.Start = 1'b0;
         if (c == 10) begin
            bus32.Start = 1'b1; bus32.Op_Alu = ADD; bus32.Op_1 = 32'd1; bus32.Op_2 = 32'd2;
         end
         if (c == 12) bus32.Start = 1'b0;
         if (c == 20) begin bus32.Op_1 = 32'd77; bus32.Op_2 = 32'd3; end
         if (bus32.Done) done_cyc = c;
      end
      check("busy_ignore done_cycle", 32'(done_cyc), 32'd33);
      check("busy_ignore res", bus32.Res, 32'd10);

      // Back-to-back: Start issued in the Done cycle.
      bus32.Start = 1'b1; bus32.Op_Alu = ADD; bus32.Op_1 = 32'd1; bus32.Op_2 = 32'd2;
      @(negedge clk);
      bus32.Start = 1'b0;
      check("b2b done", 32'(bus32.Done), 32'd1);
      check("b2b res", bus32.Res, 32'd3);
      @(negedge clk);
      check("b2b done_pulse_end", 32'(bus32.Done), 32'd0);

      // Reset aborts an in-flight square root.
      bus32.Start = 1'b1; bus32.Op_Alu = ISQRT; bus32.Op_1 = 32'd1000;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) bus32.Start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort busy", 32'(bus32.Busy), 32'd0);
      check("abort res", bus32.Res, 32'd0);
      check("abort zf", 32'(bus32.ZF), 32'd0);
      check("abort done", 32'(bus32.Done), 32'd0);
      rst = 1'b0;
      late_done = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus32.Done) late_done++;
      end
      check("abort no_late_done", 32'(late_done), 32'd0);
      run32("after_rst add", ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1);

      run8("w8 isqrt255", ISQRT, 8'd255, 8'd0, 8'd15, 5);
      run8("w8 isqrt16",  ISQRT, 8'd16,  8'd0, 8'd4,  5);
      run8("w8 divu",     DIVU,  8'd200, 8'd7, 8'd28, 9);
      run8("w8 remu",     REMU,  8'd200, 8'd7, 8'd4,  9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
